// File: rtl/inert_spi_seq.sv
// Inertial-sensor SPI sequencer: power-up wait, init-write list, then INT- or
// trig-driven burst reads of NUM_CH 16-bit channels via an external SPI master.
module inert_spi_seq #(
  parameter int                    NUM_CH    = 4,
  parameter int                    NUM_INIT  = 4,
  parameter logic [NUM_INIT*16-1:0] INIT_CMDS = {16'h0D02, 16'h1053, 16'h1150, 16'h1460},
  parameter int                    PWRUP_W   = 16,
  parameter int                    TMO_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  input  logic                   trig,
  input  logic                   mode,
  input  logic [NUM_CH*7-1:0]    rd_addr,
  input  logic                   clr_err,
  output logic                   spi_snd,
  output logic [15:0]            spi_cmd,
  input  logic                   spi_done,
  input  logic [15:0]            spi_resp,
  output logic [NUM_CH*16-1:0]   data,
  output logic                   vld,
  output logic                   busy,
  output logic                   init_done,
  output logic                   err
);

  localparam int NB    = 2 * NUM_CH;
  localparam int K_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int IDX_W = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;

  localparam logic [2:0] S_PWRUP  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [PWRUP_W-1:0]   pw_q, pw_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [NUM_CH*16-1:0] shadow_q, shadow_d;
  logic [NUM_CH*16-1:0] data_q, data_d;
  logic [15:0]          cmd_q, cmd_d;
  logic                 snd_q, snd_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;
  logic                 init_done_q, init_done_d;
  logic                 err_q, err_d;
  logic                 int_s1_q, int_s1_d;
  logic                 int_s2_q, int_s2_d;

  logic [15:0]          init_word [NUM_INIT];
  logic [6:0]           ch_addr [NUM_CH];
  logic [IDX_W-1:0]     init_nx;
  logic [15:0]          init_cmd_nx;
  logic [K_W-1:0]       rd_k;
  logic [6:0]           rd_sel;
  logic [15:0]          rd_cmd;
  logic                 unused_resp_hi;

  assign unused_resp_hi = ^spi_resp[15:8];

  // Word 0 is the most significant word of INIT_CMDS.
  generate
    for (genvar gi = 0; gi < NUM_INIT; gi++) begin : g_init_word
      assign init_word[gi] = INIT_CMDS[(NUM_INIT-1-gi)*16 +: 16];
    end
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_addr
      assign ch_addr[gi] = rd_addr[7*gi +: 7];
    end
  endgenerate

  always_comb begin
    init_nx     = idx_q + IDX_W'(1);
    init_cmd_nx = init_word[0];
    for (int i = 0; i < NUM_INIT; i++) begin
      if (int'(init_nx) == i) init_cmd_nx = init_word[i];
    end
  end

  // Command for the next byte to read: byte 0 from IDLE, byte k+1 from READ.
  always_comb begin
    rd_k   = (state_q == S_READ) ? k_q + K_W'(1) : '0;
    rd_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_k) / 2 == c) rd_sel = ch_addr[c];
    end
    rd_cmd = {1'b1, rd_sel + {6'd0, rd_k[0]}, 8'h00};
  end

  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    tmo_d       = tmo_q;
    idx_d       = idx_q;
    k_d         = k_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    cmd_d       = cmd_q;
    snd_d       = 1'b0;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    err_d       = err_q & ~clr_err;
    int_s1_d    = INT;
    int_s2_d    = int_s1_q;

    case (state_q)
      S_PWRUP: begin
        pw_d = pw_q + PWRUP_W'(1);
        if (&pw_q) begin
          snd_d   = 1'b1;
          cmd_d   = init_word[0];
          idx_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (spi_done) begin
          if (int'(idx_q) < NUM_INIT - 1) begin
            snd_d = 1'b1;
            cmd_d = init_cmd_nx;
            idx_d = init_nx;
          end else begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (&tmo_q) begin
          err_d = 1'b1;
          snd_d = 1'b1;
          cmd_d = init_word[0];
          idx_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_IDLE: begin
        if ((!mode && int_s2_q) || (mode && trig)) begin
          snd_d   = 1'b1;
          cmd_d   = rd_cmd;
          k_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (spi_done) begin
          for (int b = 0; b < NB; b++) begin
            if (int'(k_q) == b) shadow_d[8*b +: 8] = spi_resp[7:0];
          end
          if (int'(k_q) < NB - 1) begin
            snd_d = 1'b1;
            cmd_d = rd_cmd;
            k_d   = rd_k;
          end else begin
            // Publish together with the last byte so data never shows a partial frame.
            data_d  = shadow_d;
            vld_d   = 1'b1;
            state_d = S_UPDATE;
          end
        end else if (&tmo_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_PWRUP;
      end
    endcase

    if (snd_d) tmo_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      pw_q        <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      cmd_q       <= '0;
      snd_q       <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      int_s1_q    <= 1'b0;
      int_s2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      cmd_q       <= cmd_d;
      snd_q       <= snd_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      int_s1_q    <= int_s1_d;
      int_s2_q    <= int_s2_d;
    end
  end

  assign spi_snd   = snd_q;
  assign spi_cmd   = cmd_q;
  assign data      = data_q;
  assign vld       = vld_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign err       = err_q;

endmodule
